// File: rtl/module_entry_ctrl_if.sv
// rtl/module_entry_ctrl_if.sv - operand-entry sequencer signal bundle
// master drives the switch/button/done inputs; slave is the sequencer.
interface module_entry_ctrl_if #(
  parameter int DIGITS = 3
);
  logic [3:0]          gray;
  logic                enter;
  logic                clear;
  logic                op_done;
  logic [4*DIGITS-1:0] first_num;
  logic [4*DIGITS-1:0] second_num;
  logic                op_start;
  logic [1:0]          digit_cnt;
  logic [2:0]          state;
  logic                err;
  logic                timeout;

  modport master (
    output gray, enter, clear, op_done,
    input  first_num, second_num, op_start, digit_cnt, state, err, timeout
  );

  modport slave (
    input  gray, enter, clear, op_done,
    output first_num, second_num, op_start, digit_cnt, state, err, timeout
  );
endinterface

// File: rtl/module_entry_ctrl.sv
// rtl/module_entry_ctrl.sv - dip-switch operand entry, arithmetic launch and watchdog
// Collects two Gray-coded BCD operands, pulses op_start, waits for op_done, holds results.
module module_entry_ctrl #(
  parameter int DIGITS      = 3,
  parameter int WDOG_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst,
  module_entry_ctrl_if.slave bus
);
  localparam int W    = 4 * DIGITS;
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    first_q, first_d;
  logic [W-1:0]    second_q, second_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic            timeout_q, timeout_d;

  logic [3:0] bin;
  logic       digit_ok;
  logic       last_digit;
  logic       wd_expired;

  // Each binary bit is the XOR of all Gray bits at or above it.
  assign bin[3]     = bus.gray[3];
  assign bin[2]     = bus.gray[3] ^ bus.gray[2];
  assign bin[1]     = bus.gray[3] ^ bus.gray[2] ^ bus.gray[1];
  assign bin[0]     = ^bus.gray;
  assign digit_ok   = (bin <= 4'd9);
  assign last_digit = (cnt_q == 2'(DIGITS - 1));
  assign wd_expired = (wd_q == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ENTER_A;
      first_q   <= '0;
      second_q  <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      second_q  <= second_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      start_q   <= start_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    second_d  = second_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    timeout_d = timeout_q;

    if (bus.clear) begin
      state_d   = ENTER_A;
      first_d   = '0;
      second_d  = '0;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (bus.enter) begin
            if (digit_ok) begin
              if (state_q == ENTER_A) first_d = {first_q[W-5:0], bin};
              else                    second_d = {second_q[W-5:0], bin};
              if (last_digit) begin
                cnt_d   = '0;
                state_d = (state_q == ENTER_A) ? ENTER_B : START;
              end else begin
                cnt_d = cnt_q + 2'd1;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        // op_start is registered here so a clear in START suppresses it.
        START: begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.op_done) begin
            state_d = SHOW;
          end else if (wd_expired) begin
            timeout_d = 1'b1;
            state_d   = SHOW;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        SHOW: ;
        default: state_d = ENTER_A;
      endcase
    end
  end

  assign bus.first_num  = first_q;
  assign bus.second_num = second_q;
  assign bus.op_start   = start_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.state      = state_q;
  assign bus.err        = err_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_module_entry_ctrl.sv
// tb/tb_module_entry_ctrl.sv - scoreboard bench for module_entry_ctrl
// Stimulus pushes model predictions; a monitor pops and compares after each clock edge.
module tb_module_entry_ctrl;
  localparam int DIGITS = 3;
  localparam int WDOG   = 40;
  localparam int W      = 4 * DIGITS;

  localparam int P_A = 0, P_B = 1, P_START = 2, P_WAIT = 3, P_SHOW = 4;

  typedef struct {
    logic [W-1:0] first;
    logic [W-1:0] second;
    logic         start;
    logic [1:0]   cnt;
    logic [2:0]   st;
    logic         err;
    logic         tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  module_entry_ctrl_if #(.DIGITS(DIGITS)) bus ();

  module_entry_ctrl #(.DIGITS(DIGITS), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  exp_t exp_q[$];

  // Reference model: operands kept as decimal integers, phase as a plain number.
  int m_phase, m_a, m_b, m_cnt, m_wait, m_tmo, m_err, m_start;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = P_A; m_a = 0; m_b = 0; m_cnt = 0; m_wait = 0;
    m_tmo = 0; m_err = 0; m_start = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input bit done, input int v);
    m_err = 0;
    m_start = 0;
    if (clr) begin
      m_phase = P_A; m_a = 0; m_b = 0; m_cnt = 0; m_tmo = 0;
    end else begin
      case (m_phase)
        P_A, P_B: if (en) begin
          if (v <= 9) begin
            if (m_phase == P_A) m_a = (m_a * 10 + v) % pow10(DIGITS);
            else                m_b = (m_b * 10 + v) % pow10(DIGITS);
            m_cnt++;
            if (m_cnt == DIGITS) begin
              m_cnt = 0;
              m_phase = (m_phase == P_A) ? P_B : P_START;
            end
          end else begin
            m_err = 1;
          end
        end
        P_START: begin
          m_start = 1; m_wait = 0; m_phase = P_WAIT;
        end
        P_WAIT: begin
          m_wait++;
          if (done) m_phase = P_SHOW;
          else if (m_wait == WDOG) begin
            m_tmo = 1; m_phase = P_SHOW;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit en, input bit clr, input bit done, input int v);
    exp_t e;
    logic [3:0] b;
    @(negedge clk);
    b = 4'(v);
    bus.gray    = b ^ (b >> 1);
    bus.enter   = en;
    bus.clear   = clr;
    bus.op_done = done;
    model_step(en, clr, done, v);
    e.first  = to_bcd(m_a);
    e.second = to_bcd(m_b);
    e.start  = 1'(m_start);
    e.cnt    = 2'(m_cnt);
    e.st     = 3'(m_phase);
    e.err    = 1'(m_err);
    e.tmo    = 1'(m_tmo);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic enter_digits(input int d0, input int d1, input int d2);
    step(1, 0, 0, d0);
    step(1, 0, 0, d1);
    step(1, 0, 0, d2);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (bus.first_num === '0 && bus.second_num === '0 && bus.op_start === 1'b0 &&
        bus.digit_cnt === 2'd0 && bus.state === 3'd0 && bus.err === 1'b0 &&
        bus.timeout === 1'b0)
      passed++;
    else
      $display("FAIL %s got first=%h second=%h start=%b cnt=%0d st=%0d err=%b tmo=%b want all zero",
               name, bus.first_num, bus.second_num, bus.op_start, bus.digit_cnt,
               bus.state, bus.err, bus.timeout);
  endtask

  // Asynchronous reset dropped between clock edges, released on a falling edge.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    bus.enter = 1'b0; bus.clear = 1'b0; bus.op_done = 1'b0;
    rst = 1'b0;
    #1;
    check_reset(name);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.first_num === e.first && bus.second_num === e.second &&
          bus.op_start === e.start && bus.digit_cnt === e.cnt && bus.state === e.st &&
          bus.err === e.err && bus.timeout === e.tmo)
        passed++;
      else
        $display("FAIL cycle t=%0t got first=%h second=%h start=%b cnt=%0d st=%0d err=%b tmo=%b want first=%h second=%h start=%b cnt=%0d st=%0d err=%b tmo=%b",
                 $time, bus.first_num, bus.second_num, bus.op_start, bus.digit_cnt,
                 bus.state, bus.err, bus.timeout, e.first, e.second, e.start, e.cnt,
                 e.st, e.err, e.tmo);
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    bus.gray = 4'd0; bus.enter = 1'b0; bus.clear = 1'b0; bus.op_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("power_on_reset");
    @(negedge clk);
    rst = 1'b1;

    // 123 / 456, launch, then let the watchdog expire and clear.
    enter_digits(1, 2, 3);
    enter_digits(4, 5, 6);
    idle(1);
    idle(WDOG + 2);
    step(1, 0, 0, 7);
    step(0, 1, 0, 0);

    // Rejected digit 10, then 9 accepted.
    step(1, 0, 0, 10);
    step(1, 0, 0, 9);
    step(1, 0, 0, 15);
    step(1, 0, 0, 0);
    step(1, 0, 0, 8);
    enter_digits(9, 0, 1);
    idle(1);
    idle(4);
    step(0, 0, 1, 0);
    step(1, 0, 0, 3);
    step(1, 0, 0, 4);
    step(0, 1, 0, 0);

    // op_done on the exact expiry cycle beats the timeout.
    enter_digits(2, 4, 6);
    enter_digits(8, 0, 2);
    idle(1);
    idle(WDOG - 1);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);

    // clear during START suppresses op_start.
    enter_digits(3, 3, 3);
    enter_digits(4, 4, 4);
    step(0, 1, 0, 0);
    idle(2);

    // Async reset mid-entry, then enter and clear together.
    step(1, 0, 0, 5);
    step(1, 0, 0, 6);
    async_reset("async_reset_mid_entry");
    step(1, 0, 0, 7);
    step(1, 1, 0, 8);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      bit en, clr, done;
      en   = ($urandom_range(0, 99) < 40);
      clr  = ($urandom_range(0, 99) < 3);
      done = ($urandom_range(0, 99) < 5);
      step(en, clr, done, int'($urandom_range(0, 15)));
    end
    idle(2);
    @(posedge clk);
    #2;

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
